// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  // Register 31 is the zero register; it never carries a real dependency.
  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and flag stalls, taken-branch flushes,
// and free-running stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rn_id,
  input  logic [4:0]  Rm_id,
  input  logic        use_rn_id,
  input  logic        use_rm_id,
  input  logic        cond_id,
  input  logic [4:0]  Rd_ex,
  input  logic        MemtoReg_ex,
  input  logic        RegWrite_ex,
  input  logic        update_ex,
  input  logic        br_taken_ex,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  hz_state_e   r_state;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic w_lu;
  logic w_fh;
  logic w_hazard_stall;
  logic w_flush_now;

  assign w_lu = MemtoReg_ex && RegWrite_ex && (Rd_ex != XZR) &&
                ((use_rn_id && (Rn_id == Rd_ex)) || (use_rm_id && (Rm_id == Rd_ex)));
  assign w_fh = cond_id && update_ex;

  // Hazards are only acted on from RUN; a branch resolving in EX overrides them.
  assign w_hazard_stall = (r_state == RUN) && !br_taken_ex && (w_lu || w_fh);
  assign w_flush_now    = br_taken_ex || (r_state == FLUSH);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (w_flush_now) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_hazard_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_hazard_stall)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_now)
        r_flush_cnt <= r_flush_cnt + 32'd1;

      // STALL and FLUSH last one cycle unless a new taken branch re-arms FLUSH.
      case (r_state)
        RUN: begin
          if (br_taken_ex)
            r_state <= FLUSH;
          else if (w_lu || w_fh)
            r_state <= STALL;
          else
            r_state <= RUN;
        end
        STALL, FLUSH: begin
          if (br_taken_ex)
            r_state <= FLUSH;
          else
            r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  Rn_id, Rm_id, Rd_ex;
  logic        use_rn_id, use_rm_id, cond_id;
  logic        MemtoReg_ex, RegWrite_ex, update_ex, br_taken_ex;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp;
  int n_bad;

  // Behavioural model: a taken branch squashes this cycle and the next one;
  // a hazard costs exactly one bubble and is not re-examined in that bubble.
  bit          m_flush_pending;
  bit          m_just_stalled;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .Rn_id(Rn_id), .Rm_id(Rm_id), .use_rn_id(use_rn_id), .use_rm_id(use_rm_id),
    .cond_id(cond_id), .Rd_ex(Rd_ex), .MemtoReg_ex(MemtoReg_ex),
    .RegWrite_ex(RegWrite_ex), .update_ex(update_ex), .br_taken_ex(br_taken_ex),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    Rn_id = 5'd0; Rm_id = 5'd0; Rd_ex = 5'd0;
    use_rn_id = 0; use_rm_id = 0; cond_id = 0;
    MemtoReg_ex = 0; RegWrite_ex = 0; update_ex = 0; br_taken_ex = 0;
  endtask

  task automatic model_clear();
    m_flush_pending = 0; m_just_stalled = 0;
    m_stalls = 32'd0; m_flushes = 32'd0;
  endtask

  // One clock of stimulus: drive at negedge, check outputs mid-cycle, advance model.
  task automatic step(input string name,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                      input bit urn, input bit urm, input bit cnd,
                      input bit mtr, input bit rw, input bit upd, input bit br);
    bit         lu, fh;
    logic [3:0] exp_o, got_o;
    @(negedge clk);
    Rn_id = rn; Rm_id = rm; Rd_ex = rd; use_rn_id = urn; use_rm_id = urm;
    cond_id = cnd; MemtoReg_ex = mtr; RegWrite_ex = rw; update_ex = upd; br_taken_ex = br;
    #1;
    lu = mtr && rw && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
    fh = cnd && upd;
    if (br || m_flush_pending)            exp_o = 4'b1111;
    else if (!m_just_stalled && (lu || fh)) exp_o = 4'b0001;
    else                                  exp_o = 4'b1100;
    got_o = {pc_en, ifid_en, ifid_flush, idex_bubble};
    $display("[%0t] %s outs=%b cnt=%0d/%0d", $time, name, got_o, stall_cnt, flush_cnt);
    n_cmp++;
    if (got_o !== exp_o) begin
      n_bad++;
      $display("FAIL %s outputs got=%b want=%b", name, got_o, exp_o);
    end
    n_cmp++;
    if (stall_cnt !== m_stalls) begin
      n_bad++;
      $display("FAIL %s stall_cnt got=%h want=%h", name, stall_cnt, m_stalls);
    end
    n_cmp++;
    if (flush_cnt !== m_flushes) begin
      n_bad++;
      $display("FAIL %s flush_cnt got=%h want=%h", name, flush_cnt, m_flushes);
    end
    if (exp_o[1]) m_flushes = m_flushes + 32'd1;
    if (exp_o == 4'b0001) m_stalls = m_stalls + 32'd1;
    m_just_stalled  = (exp_o == 4'b0001);
    m_flush_pending = br;
  endtask

  task automatic idle(input string name);
    step(name, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    idle("reset_state");
  endtask

  task automatic test_load_use();
    apply_reset();
    // LDUR X1 in EX, ADD reading X1 via Rn in ID.
    step("lu_rn", 5'd1, 5'd7, 5'd1, 1, 1, 0, 1, 1, 0, 0);
    idle("lu_after");
    step("lu_rm", 5'd4, 5'd9, 5'd9, 0, 1, 0, 1, 1, 0, 0);
    idle("lu_rm_after");
    step("lu_unused_rn", 5'd3, 5'd0, 5'd3, 0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic test_xzr();
    apply_reset();
    step("xzr_load", 5'd31, 5'd31, 5'd31, 1, 1, 0, 1, 1, 0, 0);
    idle("xzr_after");
  endtask

  task automatic test_flush_priority();
    apply_reset();
    step("br_and_lu", 5'd2, 5'd0, 5'd2, 1, 0, 0, 1, 1, 0, 1);
    idle("flush_2nd");
    idle("flush_done");
  endtask

  task automatic test_flag();
    apply_reset();
    step("subs_bcond", 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 1, 1, 0);
    step("bcond_rerun", 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 1, 1, 0);
    step("bcond_next", 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 1, 1, 0);
    idle("flag_done");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    step("stall_enter", 5'd6, 5'd0, 5'd6, 1, 0, 0, 1, 1, 0, 0);
    step("br_in_stall", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    step("br_in_flush", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    idle("flush_tail");
    idle("b2b_done");
  endtask

  task automatic test_async_reset();
    logic [3:0] got_o;
    apply_reset();
    step("enter_flush", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive_idle();
    #2;
    reset = 1'b0;
    #1;
    got_o = {pc_en, ifid_en, ifid_flush, idex_bubble};
    $display("[%0t] async_reset outs=%b cnt=%0d/%0d", $time, got_o, stall_cnt, flush_cnt);
    n_cmp++;
    if (got_o !== 4'b1100) begin
      n_bad++;
      $display("FAIL async_reset outputs got=%b want=1100", got_o);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset counters got=%h/%h want=0/0", stall_cnt, flush_cnt);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    idle("post_reset_no_resume");
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_stalls = 32'hFFFF_FFFF;
    step("wrap_stall", 5'd8, 5'd0, 5'd8, 1, 0, 0, 1, 1, 0, 0);
    idle("wrap_zero");
  endtask

  task automatic test_random();
    logic [4:0] rn, rm, rd;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rm = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rd = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      step("rand", rn, rm, rd,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_xzr();
    test_flush_priority();
    test_flag();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset; 0 forces the reset state immediately.
REQ-003 SHALL have Rn_id, Rm_id, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have use_rn_id, use_rm_id, input, 1 each, meaning the ID instruction reads Rn or Rm.
REQ-005 SHALL have cond_id, input, 1, meaning the ID instruction is a flag-dependent conditional branch.
REQ-006 SHALL have Rd_ex, input, 5, destination of the instruction in EX.
REQ-007 SHALL have MemtoReg_ex, RegWrite_ex, update_ex, input, 1 each, EX-stage load, writeback and flag-update controls.
REQ-008 SHALL have br_taken_ex, input, 1, meaning a branch resolved taken in EX this cycle.
REQ-009 SHALL have pc_en, output, 1, PC write enable.
REQ-010 SHALL have ifid_en, output, 1, IF/ID pipeline-register load enable.
REQ-011 SHALL have ifid_flush, output, 1, meaning IF/ID loads a NOP (all control bits 0).
REQ-012 SHALL have idex_bubble, output, 1, meaning ID/EX loads a NOP.
REQ-013 SHALL have stall_cnt, flush_cnt, output, 32 each, performance counters.

Function
REQ-014 SHALL use FSM states RUN, STALL, FLUSH.
REQ-015 SHALL detect a load-use hazard (lu) when MemtoReg_ex=1, RegWrite_ex=1, Rd_ex!=31, and either use_rn_id=1 with Rn_id==Rd_ex or use_rm_id=1 with Rm_id==Rd_ex.
REQ-016 SHALL detect a flag hazard (fh) when cond_id=1 and update_ex=1.
REQ-017 SHALL go RUN->FLUSH on br_taken_ex=1, with priority over lu and fh.
REQ-018 SHALL otherwise go RUN->STALL on lu or fh; otherwise stay in RUN.
REQ-019 SHALL in RUN drive pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-020 SHALL combinationally drive pc_en=0, ifid_en=0, idex_bubble=1 in the hazard cycle itself (RUN with lu|fh and no br_taken_ex).
REQ-021 SHALL combinationally drive ifid_flush=1 and idex_bubble=1 with pc_en=1 in the br_taken_ex cycle.
REQ-022 SHALL hold STALL exactly 1 cycle with all outputs at RUN values, then return to RUN and re-evaluate hazards; the stall is 1 bubble.
REQ-023 SHALL hold FLUSH exactly 1 cycle with ifid_flush=1 and idex_bubble=1, so two wrong-path instructions are squashed.
REQ-024 SHALL treat br_taken_ex=1 while in FLUSH or STALL as a new flush: FLUSH is re-entered for 1 further cycle.
REQ-025 SHALL increment stall_cnt once per cycle that idex_bubble=1 due to lu|fh, and flush_cnt once per cycle with ifid_flush=1.
REQ-026 SHALL let both counters wrap from 0xFFFFFFFF to 0 without saturating.
REQ-027 SHALL register outputs only through the FSM state; the hazard-cycle terms are combinational from inputs.

Reset
REQ-028 SHALL on reset=0 set state=RUN and stall_cnt=flush_cnt=0, with outputs pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-029 SHALL abandon any in-progress STALL or FLUSH when reset is asserted mid-operation, and not resume it after release.

Structure
REQ-030 SHALL place the state enum (RUN, STALL, FLUSH) and the constant XZR=5'd31 in the shared CPU package.
REQ-031 SHALL be a single module; the counters use the existing nn_dff-style register cells or equivalent always_ff, with no further sub-module.

Verification
REQ-032 SHALL cover: LDUR X1 in EX, ADD reading Rn=1 in ID -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, then RUN; stall_cnt=1.
REQ-033 SHALL cover: load with Rd_ex=31 and Rn_id=31 -> no stall, stall_cnt stays 0.
REQ-034 SHALL cover: br_taken_ex=1 together with lu=1 -> flush wins; ifid_flush=1 for 2 cycles; flush_cnt=2; stall_cnt=0.
REQ-035 SHALL cover: SUBS in EX (update_ex=1) with B.cond in ID -> 1-cycle bubble.
REQ-036 SHALL cover: reset=0 asserted asynchronously mid-FLUSH -> outputs return to RUN values before the next clock edge, and counters read 0.
REQ-037 SHALL cover: stall_cnt preloaded by force to 0xFFFFFFFF plus one more stall -> stall_cnt reads 0.
